// File: rtl/cas_key_loader.sv
// rtl/cas_key_loader.sv - fetches, checksums and presents the CAS-Lock activation key
module cas_key_loader #(
    parameter int                KEY_W    = 64,
    parameter int                WORD_W   = 8,
    parameter int                ADDR_W   = 4,
    parameter int                TIMEOUT  = 255,
    parameter logic [WORD_W-1:0] CHK_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              zeroize,
    output logic              nvm_req,
    output logic [ADDR_W-1:0] nvm_addr,
    input  logic [WORD_W-1:0] nvm_rdata,
    input  logic              nvm_ack,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_valid,
    output logic              key_err,
    output logic              err_timeout,
    output logic              busy
);

    localparam int NWORDS = KEY_W / WORD_W;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_GAP,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  idx;
    logic [WORD_W-1:0]  chk;
    logic [WORD_W-1:0]  chk_word;
    logic [KEY_W-1:0]   shadow;
    logic [CNT_W-1:0]   cnt;

    // Load sequencer: key words accumulate in shadow and reach key_out only after the checksum matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            chk         <= '0;
            chk_word    <= '0;
            shadow      <= '0;
            cnt         <= '0;
            nvm_req     <= 1'b0;
            nvm_addr    <= '0;
            key_out     <= '0;
            key_valid   <= 1'b0;
            key_err     <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else if (zeroize) begin
            state       <= S_IDLE;
            idx         <= '0;
            shadow      <= '0;
            nvm_req     <= 1'b0;
            key_out     <= '0;
            key_valid   <= 1'b0;
            key_err     <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_start) begin
                        state       <= S_FETCH;
                        idx         <= '0;
                        chk         <= CHK_SEED;
                        shadow      <= '0;
                        cnt         <= '0;
                        nvm_req     <= 1'b1;
                        nvm_addr    <= '0;
                        key_out     <= '0;
                        key_valid   <= 1'b0;
                        key_err     <= 1'b0;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (nvm_ack) begin
                        nvm_req <= 1'b0;
                        if (idx < ADDR_W'(NWORDS)) begin
                            for (int i = 0; i < NWORDS; i++) begin
                                if (idx == ADDR_W'(i)) begin
                                    shadow[i*WORD_W +: WORD_W] <= nvm_rdata;
                                end
                            end
                            chk   <= chk ^ nvm_rdata;
                            idx   <= idx + 1'b1;
                            state <= S_GAP;
                        end else begin
                            chk_word <= nvm_rdata;
                            state    <= S_CHECK;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        nvm_req     <= 1'b0;
                        key_err     <= 1'b1;
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    state    <= S_FETCH;
                    nvm_req  <= 1'b1;
                    nvm_addr <= idx;
                    cnt      <= '0;
                end
                S_CHECK: begin
                    busy <= 1'b0;
                    if (chk_word == chk) begin
                        key_out   <= shadow;
                        key_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        key_err <= 1'b1;
                        state   <= S_ERR;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    nvm_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cas_key_loader.sv
// tb/tb_cas_key_loader.sv - scoreboard bench for cas_key_loader
module tb_cas_key_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        zeroize = 1'b0;
    logic        nvm_req;
    logic [3:0]  nvm_addr;
    logic [7:0]  nvm_rdata = 8'h00;
    logic        nvm_ack = 1'b0;
    logic [63:0] key_out;
    logic        key_valid;
    logic        key_err;
    logic        err_timeout;
    logic        busy;

    cas_key_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .zeroize     (zeroize),
        .nvm_req     (nvm_req),
        .nvm_addr    (nvm_addr),
        .nvm_rdata   (nvm_rdata),
        .nvm_ack     (nvm_ack),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .key_err     (key_err),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] key;
        logic        valid;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] mem [0:8];
    int         wait_states = 0;
    int         stall_addr = -1;
    int         wcount = 0;

    localparam logic [63:0] GOOD_KEY = 64'h0123456789ABCDEF;
    localparam logic [63:0] ALT_KEY  = 64'h8877665544332211;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // NVM model: acks after wait_states cycles of held request, never on stall_addr
    initial begin
        forever begin
            @(negedge clk);
            if (nvm_req && int'(nvm_addr) != stall_addr) begin
                if (wcount >= wait_states) begin
                    nvm_ack   = 1'b1;
                    nvm_rdata = mem[nvm_addr];
                    wcount    = 0;
                end else begin
                    nvm_ack = 1'b0;
                    wcount++;
                end
            end else begin
                nvm_ack = 1'b0;
                wcount  = 0;
            end
        end
    end

    // Monitor: every end of a load (busy falling) is compared against the next expected outcome
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_load_end", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_key_out", key_out, e.key);
                    check("mon_flags", {61'd0, key_valid, key_err, err_timeout},
                          {61'd0, e.valid, e.err, e.tmo});
                end
            end
            prev_busy = busy;
        end
    end

    task automatic set_mem(input logic [63:0] key, input logic [7:0] cw);
        for (int i = 0; i < 8; i++) mem[i] = key[i*8 +: 8];
        mem[8] = cw;
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // edges counts rising edges from the one that samples load_start (inclusive) to key_valid
    task automatic timed_load(output int edges, output int gmin, output int gmax);
        int run;
        run   = 0;
        gmin  = 1000;
        gmax  = 0;
        start_load();
        check("valid_clears_on_start", {63'd0, key_valid}, 64'd0);
        edges = 1;
        while (!key_valid && edges < 400) begin
            if (busy && !nvm_req) run++;
            else if (nvm_req && run > 0) begin
                if (run < gmin) gmin = run;
                if (run > gmax) gmax = run;
                run = 0;
            end
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int c;
        c = 0;
        while (busy && c < limit) begin
            @(negedge clk);
            c++;
        end
        if (busy) check("wait_idle_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int edges, gmin, gmax, tcount, c;

        #1;
        check("reset_outputs",
              {key_out[59:0], nvm_req, nvm_addr, key_valid, key_err, err_timeout, busy} == '0 ? 64'd0 : 64'd1,
              64'd0);
        check("reset_key", key_out, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_req", {63'd0, nvm_req}, 64'd0);

        // good load, zero-wait
        set_mem(GOOD_KEY, 8'hA5);
        exp_q.push_back('{GOOD_KEY, 1'b1, 1'b0, 1'b0});
        timed_load(edges, gmin, gmax);
        check("latency_first", 64'(edges), 64'd19);
        wait_idle(50);

        // reload from DONE
        exp_q.push_back('{GOOD_KEY, 1'b1, 1'b0, 1'b0});
        timed_load(edges, gmin, gmax);
        check("latency_reload", 64'(edges), 64'd19);
        check("gap_min", 64'(gmin), 64'd1);
        check("gap_max", 64'(gmax), 64'd1);
        wait_idle(50);

        // bad checksum
        set_mem(GOOD_KEY, 8'hA4);
        exp_q.push_back('{64'd0, 1'b0, 1'b1, 1'b0});
        start_load();
        wait_idle(100);

        // recovery
        set_mem(GOOD_KEY, 8'hA5);
        exp_q.push_back('{GOOD_KEY, 1'b1, 1'b0, 1'b0});
        start_load();
        wait_idle(100);

        // 3 wait states per word, different key (checksum 8'h2D)
        wait_states = 3;
        set_mem(ALT_KEY, 8'h2D);
        exp_q.push_back('{ALT_KEY, 1'b1, 1'b0, 1'b0});
        start_load();
        wait_idle(200);

        // timeout on word 3
        wait_states = 0;
        stall_addr  = 3;
        set_mem(GOOD_KEY, 8'hA5);
        exp_q.push_back('{64'd0, 1'b0, 1'b1, 1'b1});
        start_load();
        tcount = 0;
        c = 0;
        while (busy && c < 2000) begin
            if (nvm_req && nvm_addr == 4'd3) tcount++;
            @(negedge clk);
            c++;
        end
        check("timeout_req_cycles", 64'(tcount), 64'd255);
        check("timeout_req_dropped", {63'd0, nvm_req}, 64'd0);
        wait_idle(10);
        stall_addr = -1;

        // good load, then zeroize in DONE with simultaneous load_start
        exp_q.push_back('{GOOD_KEY, 1'b1, 1'b0, 1'b0});
        start_load();
        wait_idle(100);
        zeroize    = 1'b1;
        load_start = 1'b1;
        @(negedge clk);
        zeroize    = 1'b0;
        load_start = 1'b0;
        check("zeroize_key", key_out, 64'd0);
        check("zeroize_flags", {60'd0, key_valid, key_err, busy, nvm_req}, 64'd0);
        repeat (3) @(negedge clk);
        check("zeroize_ignores_start", {63'd0, nvm_req}, 64'd0);
        exp_q.push_back('{GOOD_KEY, 1'b1, 1'b0, 1'b0});
        start_load();
        wait_idle(100);

        // reset mid-load during word 5
        start_load();
        c = 0;
        while (!(nvm_req && nvm_addr == 4'd5) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("reached_word5", {63'd0, nvm_req}, 64'd1);
        exp_q.push_back('{64'd0, 1'b0, 1'b0, 1'b0});
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_key", key_out, 64'd0);
        check("async_reset_ctl", {56'd0, nvm_req, nvm_addr, key_valid, busy, key_err},
              64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_idle", {62'd0, nvm_req, busy}, 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
